// File: rtl/tpu_postproc.sv
// Column PSUM post-processing: capture into a pending buffer, strictly in-order group issue,
// then bias add, scale multiply, rounding shift and signed saturation onto a valid/ready port.
module tpu_postproc #(
  parameter int N      = 8,
  parameter int LANES  = 2,
  parameter int PSUM_W = 32,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*PSUM_W-1:0]    psum_i,
  input  logic [N-1:0]           psum_valid_i,
  input  logic                   cfg_we_i,
  input  logic [1:0]             cfg_sel_i,
  input  logic [IDX_W-1:0]       cfg_idx_i,
  input  logic [31:0]            cfg_data_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
  output logic [IDX_W-1:0]       out_idx_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   overflow_o
);
  localparam int SUM_W  = ((PSUM_W > 32) ? PSUM_W : 32) + 1;
  localparam int PROD_W = SUM_W + 32;
  localparam int RND_W  = PROD_W + 1;
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PSUM_W-1:0] buf_q   [N];
  logic signed [31:0]       bias_q  [N];
  logic signed [31:0]       scale_q [N];
  logic [N-1:0]             pending_q, pending_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [5:0]               shift_q;
  logic                     overflow_q;

  logic                     s1_valid_q, s2_valid_q, out_valid_q;
  logic [IDX_W-1:0]         s1_idx_q, s2_idx_q, out_idx_q;
  logic signed [SUM_W-1:0]  s1_sum_q   [LANES];
  logic signed [31:0]       s1_scale_q [LANES];
  logic signed [PROD_W-1:0] s2_prod_q  [LANES];
  logic [LANES*OUT_W-1:0]   out_data_q;

  logic                     stall, grp_ready, issue, cfg_idx_ok;
  logic [N-1:0]             issue_mask;
  logic [IDX_W-1:0]         lane_col [LANES];
  logic signed [SUM_W-1:0]  sum_d    [LANES];
  logic signed [31:0]       scale_d  [LANES];
  logic signed [PROD_W-1:0] prod_d   [LANES];
  logic [LANES*OUT_W-1:0]   sat_d;

  assign stall      = out_valid_q & ~out_ready_i;
  assign cfg_idx_ok = (32'(cfg_idx_i) < 32'(N));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [SUM_W-1:0]  psum_ext, bias_ext;
    logic signed [PROD_W-1:0] sum_ext, scale_ext;
    logic signed [RND_W-1:0]  prod_ext, half, rnd, r;
    logic [OUT_W-1:0]         sat;

    assign lane_col[gi] = ptr_q + IDX_W'(gi);
    assign psum_ext     = SUM_W'(buf_q[lane_col[gi]]);
    assign bias_ext     = SUM_W'(bias_q[lane_col[gi]]);
    assign sum_d[gi]    = psum_ext + bias_ext;
    assign scale_d[gi]  = scale_q[lane_col[gi]];

    // Operands are widened first so the product is exact before truncation to PROD_W.
    assign sum_ext      = PROD_W'(s1_sum_q[gi]);
    assign scale_ext    = PROD_W'(s1_scale_q[gi]);
    assign prod_d[gi]   = sum_ext * scale_ext;
    assign prod_ext     = RND_W'(s2_prod_q[gi]);

    always_comb begin
      half = '0;
      rnd  = prod_ext;
      r    = prod_ext;
      if (shift_q != 6'd0) begin
        half[shift_q - 6'd1] = 1'b1;
        rnd = prod_ext + half;
        r   = rnd >>> shift_q;
      end
      if (r > SAT_MAX)      sat = {1'b0, {(OUT_W-1){1'b1}}};
      else if (r < SAT_MIN) sat = {1'b1, {(OUT_W-1){1'b0}}};
      else                  sat = r[OUT_W-1:0];
    end

    assign sat_d[gi*OUT_W +: OUT_W] = sat;
  end

  always_comb begin
    grp_ready = 1'b1;
    for (int l = 0; l < LANES; l++) grp_ready = grp_ready & pending_q[lane_col[l]];
  end

  assign issue = grp_ready & ~stall;

  // A column re-strobed while issuing keeps its pending bit for the new value.
  always_comb begin
    issue_mask = '0;
    for (int l = 0; l < LANES; l++) issue_mask[lane_col[l]] = issue;
    pending_d = psum_valid_i | (pending_q & ~issue_mask);
    ptr_d     = ptr_q;
    if (issue) ptr_d = (ptr_q == IDX_W'(N - LANES)) ? '0 : ptr_q + IDX_W'(LANES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      ptr_q       <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_idx_q    <= '0;
      s2_idx_q    <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      for (int c = 0; c < N; c++) begin
        buf_q[c]   <= '0;
        bias_q[c]  <= '0;
        scale_q[c] <= 32'sd1;
      end
      for (int l = 0; l < LANES; l++) begin
        s1_sum_q[l]   <= '0;
        s1_scale_q[l] <= '0;
        s2_prod_q[l]  <= '0;
      end
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      if (|(psum_valid_i & pending_q & ~issue_mask)) overflow_q <= 1'b1;
      for (int c = 0; c < N; c++) begin
        if (psum_valid_i[c]) buf_q[c] <= psum_i[c*PSUM_W +: PSUM_W];
      end

      if (cfg_we_i) begin
        case (cfg_sel_i)
          2'd0:    if (cfg_idx_ok) bias_q[cfg_idx_i] <= cfg_data_i;
          2'd1:    if (cfg_idx_ok) scale_q[cfg_idx_i] <= cfg_data_i;
          2'd2:    shift_q <= (cfg_data_i[5:0] > 6'd62) ? 6'd62 : cfg_data_i[5:0];
          default: ;
        endcase
      end

      if (!stall) begin
        s1_valid_q  <= issue;
        s1_idx_q    <= ptr_q;
        s2_valid_q  <= s1_valid_q;
        s2_idx_q    <= s1_idx_q;
        out_valid_q <= s2_valid_q;
        out_idx_q   <= s2_idx_q;
        out_data_q  <= sat_d;
        for (int l = 0; l < LANES; l++) begin
          s1_sum_q[l]   <= sum_d[l];
          s1_scale_q[l] <= scale_d[l];
          s2_prod_q[l]  <= prod_d[l];
        end
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (|pending_q) | s1_valid_q | s2_valid_q | out_valid_q;

endmodule

// File: tb/tb_tpu_postproc.sv
// Directed bench for tpu_postproc: expected beats queued at stimulus time, checked on each handshake.
module tb_tpu_postproc;
  localparam int N      = 8;
  localparam int LANES  = 2;
  localparam int PSUM_W = 32;
  localparam int OUT_W  = 8;
  localparam int IDX_W  = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N*PSUM_W-1:0]    psum_i;
  logic [N-1:0]           psum_valid_i;
  logic                   cfg_we_i;
  logic [1:0]             cfg_sel_i;
  logic [IDX_W-1:0]       cfg_idx_i;
  logic [31:0]            cfg_data_i;
  logic [LANES*OUT_W-1:0] out_data_o;
  logic [IDX_W-1:0]       out_idx_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic                   busy_o;
  logic                   overflow_o;

  tpu_postproc #(.N(N), .LANES(LANES), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
    .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_idx_i(cfg_idx_i), .cfg_data_i(cfg_data_i),
    .out_data_o(out_data_o), .out_idx_o(out_idx_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0]       idx;
    logic [LANES*OUT_W-1:0] data;
  } beat_t;

  beat_t             exp_q [$];
  int                tests = 0;
  int                fails = 0;
  logic signed [31:0] pv [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input int idx, input logic [31:0] data);
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_idx_i  = IDX_W'(idx);
    cfg_data_i = data;
    tick();
    cfg_we_i   = 1'b0;
  endtask

  task automatic strobe(input logic [N-1:0] mask);
    for (int c = 0; c < N; c++) psum_i[c*PSUM_W +: PSUM_W] = pv[c];
    psum_valid_i = mask;
    tick();
    psum_valid_i = '0;
  endtask

  task automatic push(input int idx, input int l0, input int l1);
    beat_t b;
    b.idx  = IDX_W'(idx);
    b.data = {OUT_W'(l1), OUT_W'(l0)};
    exp_q.push_back(b);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic int model(input longint psum, input longint bias, input longint scale, input int sh);
    logic signed [127:0] p;
    int s;
    s = (sh > 62) ? 62 : sh;
    p = 128'(psum + bias) * 128'(scale);
    if (s > 0) p = (p + (128'sd1 <<< (s - 1))) >>> s;
    if (p > 127)  return 127;
    if (p < -128) return -128;
    return int'(p);
  endfunction

  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst && out_valid_o && out_ready_i) begin
      $display("[TB] beat idx=%0d data=%h", out_idx_o, out_data_o);
      chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_idx", 64'(out_idx_o), 64'(e.idx));
        chk("beat_data", 64'(out_data_o), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; psum_i = '0; psum_valid_i = '0; out_ready_i = 1'b1;
    cfg_we_i = 1'b0; cfg_sel_i = '0; cfg_idx_i = '0; cfg_data_i = '0;
    for (int c = 0; c < N; c++) pv[c] = 0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_data", 64'(out_data_o), 64'd0);
    chk("rst_idx", 64'(out_idx_o), 64'd0);
    rst = 1'b0;

    // Identity with defaults and 3-cycle latency.
    for (int c = 0; c < N; c++) pv[c] = c * 10;
    push(0, 0, 10); push(2, 20, 30); push(4, 40, 50); push(6, 60, 70);
    strobe('1);
    chk("lat_t0", 64'(out_valid_o), 64'd0);
    tick(); chk("lat_t1", 64'(out_valid_o), 64'd0);
    tick(); chk("lat_t2", 64'(out_valid_o), 64'd0);
    tick(); chk("lat_t3", 64'(out_valid_o), 64'd1);
    chk("lat_idx", 64'(out_idx_o), 64'd0);
    drain("identity_drain");

    // Bias, scale and rounding shift.
    cfg(2'd0, 0, 32'd28); cfg(2'd1, 0, 32'd3); cfg(2'd2, 0, 32'd2);
    pv[0] = 100; pv[1] = -7;
    push(0, 96, -2); strobe(8'h03); drain("arith_drain");

    cfg(2'd0, 0, 32'd0); cfg(2'd1, 0, 32'd1); cfg(2'd2, 0, 32'd1);
    pv[2] = 3; pv[3] = -3;
    push(2, 2, -1); strobe(8'h0C); drain("round_drain");

    cfg(2'd2, 0, 32'd0);
    pv[4] = 1000; pv[5] = -1000;
    push(4, 127, -128); strobe(8'h30); drain("sat_drain");

    cfg(2'd0, 6, 32'd1);
    pv[6] = 32'h7FFFFFFF; pv[7] = 32'h80000000;
    push(6, 127, -128); strobe(8'hC0); drain("sum33_drain");
    cfg(2'd0, 6, 32'd0);

    cfg(2'd3, 0, 32'd5);
    pv[0] = 20; pv[1] = 21;
    push(0, 20, 21); strobe(8'h03); drain("sel3_drain");

    // Shift of 63 behaves as 62.
    cfg(2'd1, 2, 32'h7FFFFFFF); cfg(2'd2, 0, 32'd63);
    pv[2] = 32'h7FFFFFFF; pv[3] = 32'h80000000;
    push(2, 1, 0); strobe(8'h0C); drain("clamp_drain");
    cfg(2'd2, 0, 32'd0); cfg(2'd1, 2, 32'd1);

    cfg(2'd0, 4, -32'sd50); cfg(2'd1, 5, -32'sd3); cfg(2'd2, 0, 32'd3);
    for (int c = 4; c < N; c++) pv[c] = int'($urandom_range(4000)) - 2000;
    push(4, model(pv[4], -50, 1, 3), model(pv[5], 0, -3, 3));
    push(6, model(pv[6], 0, 1, 3), model(pv[7], 0, 1, 3));
    strobe(8'hF0); drain("model_drain");
    cfg(2'd0, 4, 32'd0); cfg(2'd1, 5, 32'd1); cfg(2'd2, 0, 32'd0);

    // Backpressure: output held stable, then back-to-back release.
    out_ready_i = 1'b0;
    for (int c = 0; c < N; c++) pv[c] = c * 10 + 5;
    push(0, 5, 15); push(2, 25, 35); push(4, 45, 55); push(6, 65, 75);
    strobe('1); tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(out_valid_o), 64'd1);
      chk("bp_idx", 64'(out_idx_o), 64'd0);
      chk("bp_data", 64'(out_data_o), 64'h0F05);
      tick();
    end
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_valid", 64'(out_valid_o), 64'd1);
      chk("b2b_idx", 64'(out_idx_o), 64'(2 * k));
      tick();
    end
    chk("b2b_end", 64'(out_valid_o), 64'd0);
    drain("bp_drain");

    // Same-cycle capture and issue on group 0 is not an overflow.
    pv[0] = 1; pv[1] = 2;
    push(0, 1, 2); push(2, 5, 6); push(4, 7, 8); push(6, 9, 10); push(0, 3, 4);
    strobe(8'h03);
    pv[0] = 3; pv[1] = 4;
    for (int c = 2; c < N; c++) pv[c] = c + 3;
    strobe('1);
    drain("simul_drain");
    chk("simul_ovf", 64'(overflow_o), 64'd0);

    // Overflow while the output is stalled on group 2.
    out_ready_i = 1'b0;
    pv[2] = 11; pv[3] = 12;
    push(2, 11, 12); push(4, 15, 17);
    strobe(8'h0C); tick(); tick(); tick();
    chk("stall_idx", 64'(out_idx_o), 64'd2);
    pv[4] = 15; pv[5] = 16;
    strobe(8'h30);
    chk("ovf_before", 64'(overflow_o), 64'd0);
    pv[5] = 17;
    strobe(8'h20);
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("stall_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Group 0 pending early must wait for group 6 at ptr.
    pv[0] = 31; pv[1] = 32;
    push(6, 33, 34); push(0, 31, 32);
    strobe(8'h03);
    repeat (5) tick();
    chk("order_hold", 64'(out_valid_o), 64'd0);
    chk("order_busy", 64'(busy_o), 64'd1);
    pv[6] = 33; pv[7] = 34;
    strobe(8'hC0);
    drain("order_drain");

    // Reset mid-operation discards in-flight groups and config.
    cfg(2'd1, 0, 32'd5);
    for (int c = 0; c < N; c++) pv[c] = c * 7;
    strobe('1); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < N; c++) pv[c] = c * 3 + 1;
    push(0, 1, 4); push(2, 7, 10); push(4, 13, 16); push(6, 19, 22);
    strobe('1); tick(); tick();
    chk("restart_idx", 64'(out_idx_o), 64'd0);
    drain("restart_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
